// File: rtl/multiword_add_sequencer.sv
// Multi-precision adder sequencer: drives an external 8-bit add slice one byte per
// cycle (LSB first), chaining the registered carry, then offers the full sum downstream.
module multiword_add_sequencer #(
  parameter  int NBYTES = 4,
  localparam int W      = 8 * NBYTES
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_a_i,
  input  logic [W-1:0] in_b_i,
  input  logic         in_cin_i,
  output logic [7:0]   add_a_o,
  output logic [7:0]   add_b_o,
  output logic         add_cin_o,
  input  logic [7:0]   add_sum_i,
  input  logic         add_cout_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_sum_o,
  output logic         out_cout_o,
  output logic         out_ovf_o,
  output logic         busy_o
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            valid_q, valid_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          a_d     = in_a_i;
          b_d     = in_b_i;
          carry_d = in_cin_i;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        for (int i = 0; i < NBYTES; i++) begin
          if (idx_q == IW'(i)) begin
            sum_d[8*i +: 8] = add_sum_i;
          end else begin
            sum_d[8*i +: 8] = sum_q[8*i +: 8];
          end
        end
        carry_d = add_cout_i;
        if (idx_q == LAST_IDX) begin
          // Overflow judged on the captured operand signs, not the live inputs.
          idx_d   = '0;
          cout_d  = add_cout_i;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_sum_i[7] != a_q[W-1]);
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IW'(1'b1);
        end
      end
      DONE: begin
        if (out_ready_i) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // Slice operand mux: current byte in RUN, quiet zero otherwise.
  always_comb begin
    add_a_o   = 8'd0;
    add_b_o   = 8'd0;
    add_cin_o = 1'b0;
    if (state_q == RUN) begin
      add_cin_o = carry_q;
      for (int i = 0; i < NBYTES; i++) begin
        if (idx_q == IW'(i)) begin
          add_a_o = a_q[8*i +: 8];
          add_b_o = b_q[8*i +: 8];
        end else begin
          add_a_o = add_a_o;
          add_b_o = add_b_o;
        end
      end
    end else begin
      add_cin_o = 1'b0;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign busy_o      = (state_q == RUN) || (state_q == DONE);
  assign out_valid_o = valid_q;
  assign out_sum_o   = sum_q;
  assign out_cout_o  = cout_q;
  assign out_ovf_o   = ovf_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench for multiword_add_sequencer (NBYTES=4) with a behavioural 8-bit add slice.
module tb_multiword_add_sequencer;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic [7:0]   add_a;
  logic [7:0]   add_b;
  logic         add_cin;
  logic [7:0]   add_sum;
  logic         add_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  multiword_add_sequencer #(.NBYTES(NB)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_a_i      (in_a),
    .in_b_i      (in_b),
    .in_cin_i    (in_cin),
    .add_a_o     (add_a),
    .add_b_o     (add_b),
    .add_cin_o   (add_cin),
    .add_sum_i   (add_sum),
    .add_cout_i  (add_cout),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_sum_o   (out_sum),
    .out_cout_o  (out_cout),
    .out_ovf_o   (out_ovf),
    .busy_o      (busy)
  );

  // Behavioural add slice
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accept one operand set, then wait (bounded) for out_valid; reports edges and per-byte add_cin.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       output int edges, output logic [3:0] cins);
    int w;
    w = 0;
    cins = 4'b0000;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    if (!in_ready) begin
      n_fail++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
    end
    n_checks++;
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 20) begin
      if (edges < 4) cins[edges] = add_cin;
      @(posedge clk); #1;
      edges++;
    end
    if (!out_valid) begin
      n_fail++;
      $display("FAIL result_timeout: out_valid=%0b required 1", out_valid);
    end
    n_checks++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_checks++;
    if ({out_valid, out_cout, out_ovf} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000", {out_valid, out_cout, out_ovf});
    end
    n_checks++;
    if (out_sum !== 32'h0000_0000) begin n_fail++; $display("FAIL reset_sum: got %h want 0", out_sum); end
    n_checks++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int e; logic [3:0] c;
    out_ready = 1'b1;
    // wrap to zero with carry out
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, e, c);
    if (e !== 4) begin n_fail++; $display("FAIL t1_latency: got %0d want 4", e); end
    n_checks++;
    if (out_sum !== 32'h0000_0000) begin n_fail++; $display("FAIL t1_sum: got %h want 00000000", out_sum); end
    n_checks++;
    if ({out_cout, out_ovf} !== 2'b10) begin n_fail++; $display("FAIL t1_cout_ovf: got %b want 10", {out_cout, out_ovf}); end
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL t1_done_flags: busy=%0b in_ready=%0b want 1/0", busy, in_ready);
    end
    n_checks++;
    @(posedge clk); #1;
    // signed overflow positive -> negative
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, e, c);
    if (out_sum !== 32'h8000_0000) begin n_fail++; $display("FAIL t2_sum: got %h want 80000000", out_sum); end
    n_checks++;
    if ({out_cout, out_ovf} !== 2'b01) begin n_fail++; $display("FAIL t2_cout_ovf: got %b want 01", {out_cout, out_ovf}); end
    n_checks++;
    @(posedge clk); #1;
    // carry chain through two bytes
    do_op(32'h1234_5678, 32'h0000_FFFF, 1'b1, e, c);
    if (out_sum !== 32'h1235_5678) begin n_fail++; $display("FAIL t3_sum: got %h want 12355678", out_sum); end
    n_checks++;
    if ({out_cout, out_ovf} !== 2'b00) begin n_fail++; $display("FAIL t3_cout_ovf: got %b want 00", {out_cout, out_ovf}); end
    n_checks++;
    if (c !== 4'b0111) begin n_fail++; $display("FAIL t3_add_cin_seq: got %b want 0111 (byte3..0)", c); end
    n_checks++;
    @(posedge clk); #1;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL t3_return_idle: out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
    end
    n_checks++;
  endtask

  task automatic test_backpressure;
    int e; logic [3:0] c;
    out_ready = 1'b0;
    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, e, c);
    for (int k = 0; k < 5; k++) begin
      in_a = 32'hDEAD_0000 + k; in_b = 32'h0BAD_0000; in_valid = 1'b1;
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_sum !== 32'h0000_0100 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
        n_fail++; $display("FAIL t4_hold: valid=%0b sum=%h want 1/00000100", out_valid, out_sum);
      end
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL t4_in_ready: got %0b want 0", in_ready); end
      n_checks++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL t4_release: valid=%0b in_ready=%0b busy=%0b want 0/1/0", out_valid, in_ready, busy);
    end
    n_checks++;
    do_op(32'h0000_0001, 32'h0000_0002, 1'b0, e, c);
    if (out_sum !== 32'h0000_0003) begin n_fail++; $display("FAIL t4_next_sum: got %h want 00000003", out_sum); end
    n_checks++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run;
    int e; logic [3:0] c;
    out_ready = 1'b1;
    in_a = 32'h1122_3344; in_b = 32'h5566_7788; in_cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    if (add_a !== 8'h22 || add_b !== 8'h66) begin
      n_fail++; $display("FAIL t5_byte2_operands: add_a=%h add_b=%h want 22/66", add_a, add_b);
    end
    n_checks++;
    rst_n = 1'b0;
    #1;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL t5_abort: valid=%0b busy=%0b in_ready=%0b want 0/0/1", out_valid, busy, in_ready);
    end
    n_checks++;
    if ({add_a, add_b, add_cin} !== 17'd0) begin
      n_fail++; $display("FAIL t5_slice_quiet: a=%h b=%h cin=%0b want 0", add_a, add_b, add_cin);
    end
    n_checks++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(32'h8000_0000, 32'h8000_0000, 1'b0, e, c);
    if (out_sum !== 32'h0000_0000) begin n_fail++; $display("FAIL t5_sum: got %h want 00000000", out_sum); end
    n_checks++;
    if ({out_cout, out_ovf} !== 2'b11) begin n_fail++; $display("FAIL t5_cout_ovf: got %b want 11", {out_cout, out_ovf}); end
    n_checks++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] op_a [3];
    logic [W-1:0] op_b [3];
    logic [W-1:0] exp_s [3];
    logic         exp_c [3];
    int tstamp [3];
    int acc;
    int res;
    op_a[0] = 32'h0000_0001; op_b[0] = 32'h0000_0001; exp_s[0] = 32'h0000_0002; exp_c[0] = 1'b0;
    op_a[1] = 32'h0000_0010; op_b[1] = 32'h0000_0020; exp_s[1] = 32'h0000_0030; exp_c[1] = 1'b0;
    op_a[2] = 32'hFFFF_FFFF; op_b[2] = 32'hFFFF_FFFF; exp_s[2] = 32'hFFFF_FFFE; exp_c[2] = 1'b1;
    acc = 0; res = 0;
    tstamp[0] = 0; tstamp[1] = 0; tstamp[2] = 0;
    out_ready = 1'b1;
    in_cin = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        if (res < 3) begin
          if (out_sum !== exp_s[res] || out_cout !== exp_c[res]) begin
            n_fail++; $display("FAIL t6_result%0d: sum=%h cout=%0b want %h/%0b", res, out_sum, out_cout, exp_s[res], exp_c[res]);
          end
          n_checks++;
          tstamp[res] = cyc;
        end
        res++;
      end
      if (in_ready && acc < 3) begin
        in_a = op_a[acc]; in_b = op_b[acc]; in_valid = 1'b1;
        acc++;
      end else if (in_ready) begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    if (res !== 3) begin n_fail++; $display("FAIL t6_count: got %0d results want 3", res); end
    n_checks++;
    if (tstamp[1] - tstamp[0] !== 6 || tstamp[2] - tstamp[1] !== 6) begin
      n_fail++; $display("FAIL t6_spacing: got %0d,%0d want 6,6", tstamp[1] - tstamp[0], tstamp[2] - tstamp[1]);
    end
    n_checks++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
